// File: rtl/div_ctrl_pkg.sv
// Shared types and default constants for the clock-divider ratio controller.
package div_ctrl_pkg;
  typedef enum logic [1:0] {STOP, RUN, PEND, DRAIN} state_e;

  localparam int CNT_W_DEF   = 4;
  localparam int DEF_DIV_DEF = 5;
  localparam int MIN_DIV_DEF = 2;
endpackage

// File: rtl/div_period_cnt.sv
// Period counter with wrap/load-zero, period tick and registered phase decode.
module div_period_cnt #(
  parameter int CNT_W   = 4,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_run,
  input  logic             act_nxt,
  input  logic             tick_en_nxt,
  input  logic [CNT_W-1:0] cur_div,
  input  logic [CNT_W-1:0] nxt_div,
  output logic [CNT_W-1:0] div_cnt,
  output logic             wrap,
  output logic             period_tick,
  output logic             phase_hi,
  output logic             half_ext
);
  localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;
  logic             half_q, half_d;

  assign wrap = (cnt_q == cur_div - CNT_W'(1));

  // Decode from next count and next ratio so the phase flop lines up with div_cnt.
  always_comb begin
    cnt_d   = (!cnt_run || wrap) ? '0 : cnt_q + CNT_W'(1);
    tick_d  = tick_en_nxt && (cnt_d == '0);
    phase_d = act_nxt && (cnt_d < (nxt_div >> 1));
    half_d  = nxt_div[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
      half_q  <= DEF_V[0];
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      half_q  <= half_d;
    end
  end

  assign div_cnt     = cnt_q;
  assign period_tick = tick_q;
  assign phase_hi    = phase_q;
  assign half_ext    = half_q;
endmodule

// File: rtl/div_ratio_ctrl.sv
// Divide-ratio controller: start/stop FSM, request handshake, boundary-aligned ratio switch.
module div_ratio_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF,
  parameter int MIN_DIV = MIN_DIV_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_div,
  output logic             req_ready,
  output logic             req_err,
  output logic [CNT_W-1:0] cur_div,
  output logic [CNT_W-1:0] div_cnt,
  output logic             period_tick,
  output logic             phase_hi,
  output logic             half_ext,
  output logic             running
);
  localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DIV);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             accept, acc_ok, wrap;

  assign accept = req_valid && ready_q;
  assign acc_ok = accept && (req_div >= MIN_V);

  // A pending ratio exists exactly when req_ready is low.
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    ready_d    = ready_q;
    err_d      = accept && (req_div < MIN_V);
    case (state_q)
      STOP: begin
        if (acc_ok) cur_div_d = req_div;
        if (en)     state_d   = RUN;
      end
      default: begin
        if (wrap) begin
          if (!ready_q) cur_div_d = pend_div_q;
          if (acc_ok)   cur_div_d = req_div;
          ready_d = 1'b1;
        end else if (acc_ok) begin
          pend_div_d = req_div;
          ready_d    = 1'b0;
        end
        if (state_q == DRAIN) state_d = wrap ? STOP : DRAIN;
        else if (!en)         state_d = DRAIN;
        else                  state_d = ready_d ? RUN : PEND;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= STOP;
      cur_div_q  <= DEF_V;
      pend_div_q <= DEF_V;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  div_period_cnt #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_cnt (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .cnt_run     (state_q != STOP),
    .act_nxt     (state_d != STOP),
    .tick_en_nxt (state_d == RUN || state_d == PEND),
    .cur_div     (cur_div_q),
    .nxt_div     (cur_div_d),
    .div_cnt     (div_cnt),
    .wrap        (wrap),
    .period_tick (period_tick),
    .phase_hi    (phase_hi),
    .half_ext    (half_ext)
  );

  assign req_ready = ready_q;
  assign req_err   = err_q;
  assign cur_div   = cur_div_q;
  assign running   = (state_q == RUN) || (state_q == PEND);
endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Self-checking bench: period-level reference model, per-cycle compare, directed pins plus random traffic.
module tb_div_ratio_ctrl;
  localparam int CNT_W   = 4;
  localparam int DEF_DIV = 5;
  localparam int MIN_DIV = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             en = 1'b0;
  logic             req_valid = 1'b0;
  logic [CNT_W-1:0] req_div = '0;
  logic             req_ready, req_err, period_tick, phase_hi, half_ext, running;
  logic [CNT_W-1:0] cur_div, div_cnt;

  div_ratio_ctrl #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .MIN_DIV(MIN_DIV)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .req_valid(req_valid), .req_div(req_div),
    .req_ready(req_ready), .req_err(req_err), .cur_div(cur_div), .div_cnt(div_cnt),
    .period_tick(period_tick), .phase_hi(phase_hi), .half_ext(half_ext), .running(running)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: on/off, draining flag, position in period, ratio, pending ratio (-1 = none).
  int m_cur = DEF_DIV, m_cnt = 0, m_pend = -1;
  bit m_on = 0, m_drain = 0, m_err = 0;

  always @(posedge sys_clk) begin
    bit acc, last, was_drain;
    if (sys_rst) begin
      m_cur = DEF_DIV; m_cnt = 0; m_pend = -1; m_on = 0; m_drain = 0; m_err = 0;
    end else begin
      acc   = req_valid && (m_pend < 0);
      m_err = acc && (int'(req_div) < MIN_DIV);
      if (m_err) acc = 0;
      if (!m_on) begin
        if (acc) m_cur = int'(req_div);
        m_cnt = 0;
        if (en) begin m_on = 1; m_drain = 0; end
      end else begin
        was_drain = m_drain;
        last = (m_cnt == m_cur - 1);
        if (last) begin
          m_cnt = 0;
          if (m_pend >= 0) begin m_cur = m_pend; m_pend = -1; end
          if (acc) m_cur = int'(req_div);
        end else begin
          m_cnt++;
          if (acc) m_pend = int'(req_div);
        end
        if (was_drain && last) begin m_on = 0; m_drain = 0; end
        else if (!was_drain && !en) m_drain = 1;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("req_ready",   int'(req_ready),   int'(m_pend < 0));
      chk("req_err",     int'(req_err),     int'(m_err));
      chk("cur_div",     int'(cur_div),     m_cur);
      chk("div_cnt",     int'(div_cnt),     m_cnt);
      chk("running",     int'(running),     int'(m_on && !m_drain));
      chk("period_tick", int'(period_tick), int'(m_on && !m_drain && m_cnt == 0));
      chk("phase_hi",    int'(phase_hi),    int'(m_on && m_cnt < m_cur / 2));
      chk("half_ext",    int'(half_ext),    m_cur % 2);
    end
  end

  task automatic step(input logic e, input logic v, input logic [CNT_W-1:0] d, input logic r);
    en = e; req_valid = v; req_div = d; sys_rst = r;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int ticks, highs;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 0, 0);
    chk("rst_cur_div", int'(cur_div), 5);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_half", int'(half_ext), 1);
    chk("rst_running", int'(running), 0);
    chk("rst_phase", int'(phase_hi), 0);

    step(1, 0, 0, 0);
    chk("start_running", int'(running), 1);
    chk("start_tick", int'(period_tick), 1);
    ticks = 0; highs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      ticks += int'(period_tick);
      highs += int'(phase_hi);
    end
    chk("n5_ticks_in_10", ticks, 2);
    chk("n5_high_in_10", highs, 4);

    step(1, 0, 0, 0);
    chk("cnt_before_req4", int'(div_cnt), 1);
    step(1, 1, 4, 0);
    chk("pend_ready_low", int'(req_ready), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("pend_still_n5", int'(cur_div), 5);
    chk("pend_cnt4", int'(div_cnt), 4);
    step(1, 0, 0, 0);
    chk("apply_n4", int'(cur_div), 4);
    chk("apply_ready", int'(req_ready), 1);
    chk("apply_half0", int'(half_ext), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("n4_wrap_cnt", int'(div_cnt), 3);
    step(1, 1, 3, 0);
    chk("wrap_apply_n3", int'(cur_div), 3);
    chk("wrap_apply_cnt0", int'(div_cnt), 0);
    chk("wrap_apply_tick", int'(period_tick), 1);
    chk("wrap_apply_ready", int'(req_ready), 1);

    step(1, 1, 1, 0);
    chk("bad_req_err", int'(req_err), 1);
    chk("bad_req_cur", int'(cur_div), 3);
    step(1, 0, 0, 0);
    chk("bad_req_err_clr", int'(req_err), 0);
    step(1, 1, 5, 0);
    chk("back_to_n5", int'(cur_div), 5);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("drain_from_cnt2", int'(div_cnt), 2);
    step(0, 0, 0, 0);
    chk("drain_cnt3", int'(div_cnt), 3);
    chk("drain_not_running", int'(running), 0);
    step(1, 0, 0, 0);
    chk("drain_cnt4", int'(div_cnt), 4);
    step(1, 0, 0, 0);
    chk("stopped_cnt", int'(div_cnt), 0);
    chk("stopped_running", int'(running), 0);
    chk("stopped_phase", int'(phase_hi), 0);

    step(1, 0, 0, 0);
    chk("restart_running", int'(running), 1);
    step(1, 0, 0, 0);
    step(1, 1, 7, 0);
    chk("pend7_ready", int'(req_ready), 0);
    step(1, 0, 0, 1);
    chk("rst_pend_cur", int'(cur_div), 5);
    chk("rst_pend_ready", int'(req_ready), 1);
    chk("rst_pend_running", int'(running), 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("reen_cnt4", int'(div_cnt), 4);
    step(1, 0, 0, 0);
    chk("reen_wrap_tick", int'(period_tick), 1);
    chk("reen_period5_cur", int'(cur_div), 5);

    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 9) != 0),
           logic'($urandom_range(0, 2) == 0),
           CNT_W'($urandom_range(0, 15)),
           logic'($urandom_range(0, 99) == 0));
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/div_ratio_ctrl.md
Name: div_ratio_ctrl

Overview:
- Run-time controller for the integer clock-divider datapath.
- Owns the period counter, accepts divide-ratio change requests over a valid/ready handshake, and applies each change only at a period boundary, so the divided clock never produces a runt or stretched pulse.
- Drives registered phase outputs (posedge high phase, plus an odd-ratio extension flag) to the downstream clock-combining stage, which ORs a negedge-retimed copy for odd ratios.
- Handles clean start/stop of the divided clock on an enable.

Parameters:
- CNT_W, 4: width of the ratio and counter.
- DEF_DIV, 5: divide ratio loaded at reset.
- MIN_DIV, 2: smallest legal ratio. Requests below it are rejected.

Ports:
- sys_clk  in  1  system clock; all logic on posedge.
- sys_rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable for the divided clock.
- req_valid  in  1  ratio-change request valid.
- req_div  in  CNT_W  requested divide ratio N.
- req_ready  out  1  controller can accept a request.
- req_err  out  1  one-cycle pulse: illegal ratio rejected.
- cur_div  out  CNT_W  ratio currently in effect.
- div_cnt  out  CNT_W  period counter, 0..cur_div-1.
- period_tick  out  1  high in the cycle where div_cnt==0 while running.
- phase_hi  out  1  posedge high phase of the divided clock.
- half_ext  out  1  cur_div is odd; downstream negedge stage extends the high phase by half a cycle.
- running  out  1  state is RUN or PEND.

Behaviour:
- Reset (sys_rst=1 at posedge, any state, including mid-PEND or mid-DRAIN) puts the block in these values:
  - state=STOP, cur_div=DEF_DIV, div_cnt=0.
  - period_tick=0, phase_hi=0, req_ready=1, req_err=0, running=0.
  - half_ext reflects DEF_DIV.
  - Any pending ratio is discarded.
- Handshake:
  - A transfer occurs on a cycle with req_valid && req_ready.
  - req_div<MIN_DIV is consumed but rejected: req_err=1 the next cycle for exactly one cycle; cur_div, state and req_ready are unchanged.
- States:
  - STOP:
    - div_cnt held at 0; phase_hi=0 and period_tick=0.
    - A legal request updates cur_div on the next cycle and stays in STOP.
    - en=1 moves to RUN on the next cycle: div_cnt=0 and period_tick=1 in that first RUN cycle.
  - RUN:
    - div_cnt increments each cycle and wraps cur_div-1 -> 0.
    - A legal request is latched into pend_div, req_ready drops to 0 the next cycle, and the state goes to PEND. The one exception is acceptance in a wrap cycle (div_cnt==cur_div-1), which applies the new ratio at that same boundary: cur_div=new, div_cnt=0 next cycle, stay in RUN, req_ready stays 1.
    - en=0 moves to DRAIN.
  - PEND:
    - Counting continues with the old cur_div.
    - In the wrap cycle: cur_div<=pend_div, div_cnt<=0, req_ready<=1, back to RUN.
    - en=0 in PEND: go to DRAIN; pend_div is still applied at the boundary.
  - DRAIN:
    - Counting continues until the wrap cycle.
    - Then: div_cnt<=0, apply any pending ratio, req_ready<=1, go to STOP.
    - en re-asserted during DRAIN is ignored until STOP is reached.
- Phase decode:
  - phase_hi is registered. It is 1 exactly in the cycles where the running div_cnt < floor(cur_div/2), computed from the next-state count and ratio, so it is aligned with div_cnt.
  - half_ext = cur_div[0], registered together with cur_div.
  - Result: N=5 gives 2 high cycles plus half a cycle of extension, which is 50% duty after downstream combining. N=4 gives 2 high of 4.
- Width:
  - The ratio compare uses cur_div-1 at CNT_W bits; no overflow is possible since cur_div>=MIN_DIV>=2.
  - The maximum ratio is 2^CNT_W-1.
- Simultaneous events:
  - en fall and request accept in the same RUN cycle: the request is latched, then DRAIN.
  - A ratio switch takes effect only at a boundary; a period is never truncated.

Decomposition:
- Package div_ctrl_pkg holds:
  - the state enum {STOP, RUN, PEND, DRAIN};
  - default CNT_W, DEF_DIV and MIN_DIV constants.
- Sub-module div_period_cnt holds:
  - the counter with wrap and load-zero;
  - period_tick;
  - the phase_hi/half_ext decode.
- The FSM, handshake and pend_div register stay in div_ratio_ctrl.

Test Plan:
- Reset, en=1, DEF_DIV=5:
  - period_tick every 5 cycles; div_cnt 0,1,2,3,4,0...
  - phase_hi high for 2 of 5 cycles; half_ext=1.
  - running rises 1 cycle after en.
- Running at N=5, request req_div=4 accepted at div_cnt=1:
  - req_ready=0 until the wrap after div_cnt=4.
  - Next period is 4 cycles, half_ext=0, phase_hi high for 2 cycles, req_ready=1.
- Request req_div=3 accepted exactly at div_cnt=4 (wrap):
  - Next cycle cur_div=3, div_cnt=0, period_tick=1; no extra N=5 period.
- req_div=1 with valid:
  - req_err pulses 1 cycle; cur_div stays 5; counting undisturbed.
- en dropped at div_cnt=2 (N=5):
  - Counts continue 3,4; then STOP with div_cnt=0, phase_hi=0, running=0.
  - en=1 in mid-DRAIN has no effect until STOP.
- sys_rst asserted in PEND (pending 7):
  - Next cycle STOP, cur_div=5, req_ready=1; pending discarded.
  - Re-enable yields a period of 5.
